quad_encoder_tx: RTL

//   Trackball emulator: converts signed mouse motion reports into 2-axis quadrature

---
 rtl/quad_encoder_tx_pkg.sv | 25 ++
 rtl/quad_axis_gen.sv | 63 ++++++
 rtl/quad_encoder_tx.sv | 72 +++++++
 3 files changed

// File: rtl/quad_encoder_tx_pkg.sv
// Shared definitions for the trackball quadrature transmitter: accumulator
// width default, Gray phase codes and the phase stepping helper.
package quad_encoder_tx_pkg;

  localparam int ACC_W_DEF = 10;

  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b01;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b10;

  // Forward walks PH0->PH1->PH2->PH3->PH0; backward walks the reverse.
  function automatic logic [1:0] phase_step(input logic [1:0] ph, input logic fwd);
    logic [1:0] nxt;
    nxt = ph;
    case (ph)
      PH0:     nxt = fwd ? PH1 : PH3;
      PH1:     nxt = fwd ? PH2 : PH0;
      PH2:     nxt = fwd ? PH3 : PH1;
      default: nxt = fwd ? PH0 : PH2;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_axis_gen.sv
// One quadrature axis: saturating signed motion accumulator drained one
// Gray-code phase step per tick, sign of the accumulator choosing direction.
module quad_axis_gen
  import quad_encoder_tx_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               tick,
  input  logic               add_en,
  input  logic signed [ACC_W:0] delta,
  output logic [1:0]         phase,
  output logic               nonzero
);

  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [SUM_W-1:0] ONE     = SUM_W'(1);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [SUM_W-1:0] acc_x;
  logic signed [SUM_W-1:0] dlt_add;
  logic signed [SUM_W-1:0] sum;
  logic                    step_fwd;
  logic                    step_bwd;

  assign step_bwd = tick && acc[ACC_W-1];
  assign step_fwd = tick && !acc[ACC_W-1] && (acc != '0);
  assign acc_x    = {{2{acc[ACC_W-1]}}, acc};
  assign nonzero  = (acc != '0);

  // The sum is two bits wider than the accumulator so clamping sees true overflow.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    dlt_add  = '0;
    acc_next = '0;
    if (add_en) dlt_add = {delta[ACC_W], delta};
    sum = acc_x + dlt_add;
    if (step_fwd)      sum = sum - ONE;
    else if (step_bwd) sum = sum + ONE;
    if (sum > ACC_MAX)      acc_next = ACC_MAX[ACC_W-1:0];
    else if (sum < ACC_MIN) acc_next = ACC_MIN[ACC_W-1:0];
    else                    acc_next = sum[ACC_W-1:0];
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      phase <= PH0;
    end else if (clear) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
      if (step_fwd || step_bwd) phase <= phase_step(phase, step_fwd);
    end
  end

endmodule

// File: rtl/quad_encoder_tx.sv
// Trackball emulator transmit end: turns signed mouse deltas into X/Y quadrature
// phase pairs for the trackball receiver, one edge per axis per step tick.
module quad_encoder_tx
  import quad_encoder_tx_pkg::*;
#(
  parameter int STEP_DIV = 1000,
  parameter int ACC_W    = ACC_W_DEF,
  parameter bit INV_X    = 1'b0,
  parameter bit INV_Y    = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              mstrobe,
  input  logic signed [8:0] dx,
  input  logic signed [8:0] dy,
  output logic              tb_hc,
  output logic              tb_hd,
  output logic              tb_vc,
  output logic              tb_vd,
  output logic              busy
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0]     tick_cnt;
  logic                 tick;
  logic signed [ACC_W:0] dx_ext, dy_ext, d_x, d_y;
  logic [1:0]           ph_x, ph_y;
  logic                 nz_x, nz_y;

  // Free-running divider; deliberately not restarted by motion or clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              tick_cnt <= '0;
    else if (tick_cnt == CNT_LAST) tick_cnt <= '0;
    else                       tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick   = (tick_cnt == CNT_LAST);
  assign dx_ext = {{(ACC_W - 8){dx[8]}}, dx};
  assign dy_ext = {{(ACC_W - 8){dy[8]}}, dy};
  assign d_x    = INV_X ? -dx_ext : dx_ext;
  assign d_y    = INV_Y ? -dy_ext : dy_ext;

  quad_axis_gen #(.ACC_W(ACC_W)) u_axis_x (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .tick    (tick),
    .add_en  (mstrobe),
    .delta   (d_x),
    .phase   (ph_x),
    .nonzero (nz_x)
  );

  quad_axis_gen #(.ACC_W(ACC_W)) u_axis_y (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .tick    (tick),
    .add_en  (mstrobe),
    .delta   (d_y),
    .phase   (ph_y),
    .nonzero (nz_y)
  );

  assign {tb_hc, tb_hd} = ph_x;
  assign {tb_vc, tb_vd} = ph_y;
  assign busy           = nz_x | nz_y;

endmodule
